load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of the word-addressed data memory (Data_Mem).
- Converts pipeline byte addresses and RV32I funct3 access sizes (byte/half/word, signed/unsigned) into word-wide memory transactions.
- Implements sub-word stores as read-modify-write, since the memory has no byte enables.
- Produces aligned, extended load results and a stall (Busy) to the pipeline.

Parameters:
- DEPTH, 1024, memory depth in 32-bit words; word index must be < DEPTH.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Req  in  1  access request from pipeline
- MemWrite  in  1  1 = store, 0 = load
- Funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- Addr  in  32  byte address
- StoreData  in  32  store value (low byte/half used for sub-word)
- Busy  out  1  unit not accepting requests (state != IDLE)
- LoadValid  out  1  one-cycle pulse: LoadData updated
- LoadData  out  32  extended load result, held until next load
- Fault  out  1  one-cycle pulse: illegal funct3, misaligned or out-of-range access
- MemAddress  out  32  word index to memory (Addr[31:2], zero-extended)
- MemWriteData  out  32  word to memory
- MemWriteEnable  out  1  memory write strobe
- MemReadEn  out  1  memory read strobe
- MemReadData  in  32  memory read word; registered, valid the cycle after MemReadEn

Behaviour:
- Reset low: state=IDLE; Busy=0, LoadValid=0, LoadData=0, Fault=0, saved request regs cleared.
- Memory strobes are combinational and forced to 0 while Reset is low.
- States:
  - IDLE: memory outputs are driven combinationally from the live inputs.
  - LOAD_WAIT and RMW_WRITE: memory outputs are driven from request registers latched at acceptance.
- Acceptance:
  - A request is accepted at a rising edge when Req=1 and state=IDLE.
  - Req while Busy=1 is ignored; upstream holds its request.
- Fault check, combinational in IDLE, any one condition:
  - illegal funct3 (load: 011/110/111; store: anything other than 000/001/010);
  - H/HU with Addr[0]=1;
  - W with Addr[1:0]!=0;
  - Addr[31:2] >= DEPTH.
  - On fault: no memory strobes, Fault=1 the following cycle, state stays IDLE, LoadValid stays 0.
- SW: in the request cycle, MemWriteEnable=1, MemWriteData=StoreData, MemAddress=Addr[31:2]. Written at that edge; stays IDLE; Busy never asserts.
- Loads:
  - Request cycle: MemReadEn=1, MemWriteEnable=0. Edge E0 → LOAD_WAIT (Busy=1 for one cycle).
  - In LOAD_WAIT: select lane from saved Addr[1:0], little-endian (byte n = bits 8n+7:8n). Sign-extend B/H; zero-extend BU/HU; W passes unchanged.
  - At edge E1: LoadData registered, LoadValid=1 for the following cycle, → IDLE.
  - Latency: request in cycle 0, LoadValid in cycle 2.
  - A new request may be accepted in the same cycle LoadValid is high.
- SB/SH (read-modify-write):
  - Request cycle: MemReadEn=1. Edge E0 → RMW_WRITE; Busy=1.
  - RMW_WRITE: MemWriteEnable=1; MemWriteData = MemReadData with the addressed byte/half lane replaced by StoreData[7:0]/[15:0]. Write at E1 → IDLE.
  - Total occupancy: 2 cycles.
- Reset asserted mid-LOAD_WAIT or mid-RMW_WRITE:
  - The operation is abandoned: no write, no LoadValid.
  - Memory contents are unchanged for an abandoned RMW.
- No forwarding: a load issued immediately after a store observes the already-written word, because writes complete before IDLE.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined: adds outputs LoadCount, StoreCount, FaultCount (32 bits each).
  - Counters reset to 0 and increment by 1 at acceptance of a non-faulting load, acceptance of a non-faulting store, and each fault respectively.
  - Counters wrap 0xFFFFFFFF → 0.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- SW Addr=0x10, StoreData=0xDEADBEEF → same cycle MemWriteEnable=1, MemAddress=4, MemWriteData=0xDEADBEEF; Busy stays 0.
- Word 4 = 0xDEADBEEF; LB Addr=0x13 → LoadValid in cycle 2, LoadData=0xFFFFFFDE. LBU 0x13 → 0x000000DE. LH 0x12 → 0xFFFFDEAD. LHU 0x10 → 0x0000BEEF.
- SB Addr=0x11, StoreData=0x12345655 → Busy=1 for one cycle; write of 0xDEAD55EF at MemAddress=4. Following LW 0x10 → LoadData=0xDEAD55EF.
- LW Addr=0x12; SH Addr=0x13; Funct3=011 load; LW Addr=0x1000 (DEPTH=1024) → each gives a Fault pulse, no MemReadEn/MemWriteEnable, Busy=0, LoadData unchanged.
- SH Addr=0x10 with Reset pulled low during RMW_WRITE → MemWriteEnable=0 immediately, word 4 unchanged, all outputs 0; first request after release is accepted normally.
- Back-to-back: LW, then Req held high with SW during Busy → SW accepted only in the cycle after Busy falls; with LSU_PERF_CNT_EN, LoadCount=1 and StoreCount=1 afterwards.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte-addressed RV32I accesses onto a word-wide memory,
// with read-modify-write sub-word stores. Optional counters under LSU_PERF_CNT_EN.
module load_store_unit #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        LoadValid,
  output logic [31:0] LoadData,
  output logic        Fault,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWriteEnable,
  output logic        MemReadEn,
  input  logic [31:0] MemReadData
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount,
  output logic [31:0] FaultCount
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HALF = 16;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   addr_q;
  logic [HALF-1:0]   data_q;
  logic [2:0]        f3_q;
  logic              illegal_c, misalign_c, range_c, fault_c, accept_c;
  logic [XLEN-1:0]   mem_addr_c, mem_wdata_c, load_ext_c, merged_c;
  logic              mem_we_c, mem_re_c;
  logic [7:0]        lane_b_c;
  logic [HALF-1:0]   lane_h_c;

  // Request legality, evaluated only while idle
  always_comb begin
    illegal_c = 1'b1;
    case (Funct3)
      F3_B, F3_H, F3_W: illegal_c = 1'b0;
      F3_BU, F3_HU:     illegal_c = MemWrite;
      default:          illegal_c = 1'b1;
    endcase
    misalign_c = ((Funct3 == F3_H || Funct3 == F3_HU) && Addr[0]) ||
                 ((Funct3 == F3_W) && (Addr[1:0] != 2'b00));
    range_c    = {2'b00, Addr[31:2]} >= XLEN'(DEPTH);
    fault_c    = Req && (state == IDLE) && (illegal_c || misalign_c || range_c);
    accept_c   = Req && (state == IDLE) && !(illegal_c || misalign_c || range_c);
  end

  // Lane extraction for loads and lane replacement for sub-word stores
  always_comb begin
    lane_b_c = MemReadData[7:0];
    case (addr_q[1:0])
      2'd0: lane_b_c = MemReadData[7:0];
      2'd1: lane_b_c = MemReadData[15:8];
      2'd2: lane_b_c = MemReadData[23:16];
      2'd3: lane_b_c = MemReadData[31:24];
      default: lane_b_c = MemReadData[7:0];
    endcase
    lane_h_c = addr_q[1] ? MemReadData[31:16] : MemReadData[15:0];

    case (f3_q)
      F3_B:    load_ext_c = {{24{lane_b_c[7]}}, lane_b_c};
      F3_H:    load_ext_c = {{16{lane_h_c[15]}}, lane_h_c};
      F3_BU:   load_ext_c = {24'h0, lane_b_c};
      F3_HU:   load_ext_c = {16'h0, lane_h_c};
      default: load_ext_c = MemReadData;
    endcase

    merged_c = MemReadData;
    if (f3_q == F3_H) begin
      if (addr_q[1]) merged_c[31:16] = data_q;
      else           merged_c[15:0]  = data_q;
    end else begin
      case (addr_q[1:0])
        2'd0: merged_c[7:0]   = data_q[7:0];
        2'd1: merged_c[15:8]  = data_q[7:0];
        2'd2: merged_c[23:16] = data_q[7:0];
        2'd3: merged_c[31:24] = data_q[7:0];
        default: merged_c = MemReadData;
      endcase
    end
  end

  // Next state and memory-side strobes
  always_comb begin
    state_nxt   = state;
    mem_addr_c  = {2'b00, Addr[31:2]};
    mem_wdata_c = StoreData;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (MemWrite && Funct3 == F3_W) begin
            mem_we_c = 1'b1;
          end else begin
            mem_re_c  = 1'b1;
            state_nxt = MemWrite ? RMW_WRITE : LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        mem_addr_c = {2'b00, addr_q[31:2]};
        state_nxt  = IDLE;
      end
      RMW_WRITE: begin
        mem_addr_c  = {2'b00, addr_q[31:2]};
        mem_wdata_c = merged_c;
        mem_we_c    = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      LoadValid <= 1'b0;
      LoadData  <= '0;
      Fault     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      f3_q      <= '0;
    end else begin
      state     <= state_nxt;
      Fault     <= fault_c;
      LoadValid <= (state == LOAD_WAIT);
      if (state == LOAD_WAIT) LoadData <= load_ext_c;
      if (accept_c) begin
        addr_q <= Addr;
        data_q <= StoreData[HALF-1:0];
        f3_q   <= Funct3;
      end
    end
  end

  // Memory interface is silenced while reset is held so an abandoned RMW cannot write
  assign Busy           = (state != IDLE);
  assign MemWriteEnable = Reset & mem_we_c;
  assign MemReadEn      = Reset & mem_re_c;
  assign MemAddress     = Reset ? mem_addr_c : '0;
  assign MemWriteData   = Reset ? mem_wdata_c : '0;

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      LoadCount  <= '0;
      StoreCount <= '0;
      FaultCount <= '0;
    end else begin
      if (accept_c && !MemWrite) LoadCount  <= LoadCount + 32'd1;
      if (accept_c && MemWrite)  StoreCount <= StoreCount + 32'd1;
      if (fault_c)               FaultCount <= FaultCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset, Req, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, StoreData;
  logic        Busy, LoadValid, Fault, MemWriteEnable, MemReadEn;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] LoadCount, StoreCount, FaultCount;
`endif

  int vectors = 0;
  int miscompares = 0;
  int unsigned exp_lc = 0, exp_sc = 0, exp_fc = 0;
  logic [31:0] exp_load[$];
  logic [63:0] exp_wr[$];
  logic [31:0] last_load = 32'h0;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] tb_mem [0:1023];
  logic [31:0] rd_q;

  load_store_unit #(.DEPTH(1024)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .StoreData(StoreData), .Busy(Busy), .LoadValid(LoadValid),
    .LoadData(LoadData), .Fault(Fault), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWriteEnable(MemWriteEnable),
    .MemReadEn(MemReadEn), .MemReadData(MemReadData)
`ifdef LSU_PERF_CNT_EN
    , .LoadCount(LoadCount), .StoreCount(StoreCount), .FaultCount(FaultCount)
`endif
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemReadEn) rd_q <= tb_mem[MemAddress[9:0]];
    if (MemWriteEnable) tb_mem[MemAddress[9:0]] <= MemWriteData;
  end
  assign MemReadData = rd_q;

  // Scoreboard: pop expected loads and writes as the DUT produces them
  always @(negedge Clock) begin : monitor
    logic [31:0] e;
    logic [63:0] w;
    if (LoadValid) begin
      vectors++;
      if (exp_load.size() == 0) begin
        $display("FAIL load_unexpected: got LoadValid with data %h, want no load", LoadData);
        miscompares++;
      end else begin
        e = exp_load.pop_front();
        last_load = e;
        if (LoadData !== e) begin
          $display("FAIL load_data: got %h want %h", LoadData, e);
          miscompares++;
        end
      end
    end
    if (MemWriteEnable) begin
      vectors++;
      if (exp_wr.size() == 0) begin
        $display("FAIL write_unexpected: got write %h @%h, want no write", MemWriteData, MemAddress);
        miscompares++;
      end else begin
        w = exp_wr.pop_front();
        if ({MemAddress, MemWriteData} !== w) begin
          $display("FAIL write: got %h @%h want %h @%h", MemWriteData, MemAddress, w[31:0], w[63:32]);
          miscompares++;
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [31:0] s;
    s = w >> (32'(off) * 8);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] mask;
    mask = ((f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF) << (32'(off) * 8);
    return (w & ~mask) | ((d << (32'(off) * 8)) & mask);
  endfunction

  function automatic logic model_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic ill, mis, rng;
    ill = w ? !(f3 inside {3'b000, 3'b001, 3'b010})
            : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
    rng = a[31:2] >= 30'd1024;
    return ill || mis || rng;
  endfunction

  task automatic idle_in();
    Req = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000; Addr = 32'h0; StoreData = 32'h0;
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    Req = 1'b1; MemWrite = w; Funct3 = f3; Addr = a; StoreData = d;
    if (model_fault(w, f3, a)) exp_fc++;
    else if (w) exp_sc++;
    else exp_lc++;
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] e,
                          output int lat);
    exp_load.push_back(e);
    issue(1'b0, f3, a, 32'h0);
    @(negedge Clock);
    @(posedge Clock); #1 idle_in();
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clock);
      if (LoadValid) begin lat = i; break; end
    end
    @(posedge Clock); #1;
  endtask

  task automatic run_store_word(input logic [31:0] a, input logic [31:0] d);
    exp_wr.push_back({2'b00, a[31:2], d});
    ref_mem[a[11:2]] = d;
    issue(1'b1, 3'b010, a, d);
    @(negedge Clock);
    @(posedge Clock); #1 idle_in();
  endtask

  task automatic test_reset();
    Reset = 1'b0; Req = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h10; StoreData = 32'h1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    vectors++;
    if ({Busy, LoadValid, Fault, LoadData} !== 35'h0) begin
      $display("FAIL reset_regs: got busy=%b lv=%b fault=%b ld=%h want all 0", Busy, LoadValid, Fault, LoadData);
      miscompares++;
    end
    vectors++;
    if ({MemWriteEnable, MemReadEn} !== 2'b00) begin
      $display("FAIL reset_strobes: got we=%b re=%b want 0 0", MemWriteEnable, MemReadEn);
      miscompares++;
    end
    idle_in();
    @(posedge Clock); #1 Reset = 1'b1;
  endtask

  task automatic test_store_word();
    exp_wr.push_back({32'd4, 32'hDEADBEEF});
    ref_mem[4] = 32'hDEADBEEF;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    @(negedge Clock);
    vectors++;
    if ({MemWriteEnable, MemReadEn, Busy, MemAddress, MemWriteData} !== {3'b100, 32'd4, 32'hDEADBEEF}) begin
      $display("FAIL sw_request: got we=%b re=%b busy=%b addr=%h data=%h want 1 0 0 4 deadbeef",
               MemWriteEnable, MemReadEn, Busy, MemAddress, MemWriteData);
      miscompares++;
    end
    @(posedge Clock); #1 idle_in();
    @(negedge Clock);
    vectors++;
    if (Busy !== 1'b0) begin
      $display("FAIL sw_busy: got %b want 0", Busy);
      miscompares++;
    end
    @(posedge Clock); #1;
    run_store_word(32'hFFC, 32'h80C0FFEE);
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [6];
    logic [31:0] adr [6];
    logic [31:0] exs [6];
    int lat;
    f3s[0] = 3'b000; adr[0] = 32'h13;  exs[0] = 32'hFFFFFFDE;
    f3s[1] = 3'b100; adr[1] = 32'h13;  exs[1] = 32'h000000DE;
    f3s[2] = 3'b001; adr[2] = 32'h12;  exs[2] = 32'hFFFFDEAD;
    f3s[3] = 3'b101; adr[3] = 32'h10;  exs[3] = 32'h0000BEEF;
    f3s[4] = 3'b010; adr[4] = 32'hFFC; exs[4] = ref_mem[10'h3FF];
    f3s[5] = 3'b001; adr[5] = 32'hFFE; exs[5] = model_load(ref_mem[10'h3FF], 2'd2, 3'b001);
    for (int i = 0; i < 6; i++) begin
      run_load(f3s[i], adr[i], exs[i], lat);
      vectors++;
      if (lat !== 2) begin
        $display("FAIL load_latency[%0d]: got %0d cycles want 2", i, lat);
        miscompares++;
      end
    end
  endtask

  task automatic test_sub_word_store();
    logic [31:0] m;
    int lat;
    m = model_merge(ref_mem[4], 2'd1, 3'b000, 32'h12345655);
    exp_wr.push_back({32'd4, m});
    ref_mem[4] = m;
    issue(1'b1, 3'b000, 32'h11, 32'h12345655);
    @(negedge Clock);
    vectors++;
    if ({MemReadEn, MemWriteEnable, Busy} !== 3'b100) begin
      $display("FAIL sb_request: got re=%b we=%b busy=%b want 1 0 0", MemReadEn, MemWriteEnable, Busy);
      miscompares++;
    end
    @(posedge Clock); #1 idle_in();
    @(negedge Clock);
    vectors++;
    if ({Busy, MemWriteEnable, MemAddress, MemWriteData} !== {2'b11, 32'd4, 32'hDEAD55EF}) begin
      $display("FAIL sb_rmw: got busy=%b we=%b addr=%h data=%h want 1 1 4 dead55ef",
               Busy, MemWriteEnable, MemAddress, MemWriteData);
      miscompares++;
    end
    @(posedge Clock); #1;
    @(negedge Clock);
    vectors++;
    if ({Busy, MemWriteEnable} !== 2'b00) begin
      $display("FAIL sb_done: got busy=%b we=%b want 0 0", Busy, MemWriteEnable);
      miscompares++;
    end
    @(posedge Clock); #1;
    run_load(3'b010, 32'h10, 32'hDEAD55EF, lat);
    // Upper-half store at the last legal word
    m = model_merge(ref_mem[10'h3FF], 2'd2, 3'b001, 32'hAAAA1357);
    exp_wr.push_back({32'h3FF, m});
    ref_mem[10'h3FF] = m;
    issue(1'b1, 3'b001, 32'hFFE, 32'hAAAA1357);
    @(posedge Clock); #1 idle_in();
    @(posedge Clock); #1;
    run_load(3'b010, 32'hFFC, ref_mem[10'h3FF], lat);
    vectors++;
    if (lat !== 2) begin
      $display("FAIL sh_reload_latency: got %0d want 2", lat);
      miscompares++;
    end
  endtask

  task automatic test_faults();
    logic        ws  [5];
    logic [2:0]  f3s [5];
    logic [31:0] adr [5];
    ws[0] = 1'b0; f3s[0] = 3'b010; adr[0] = 32'h12;
    ws[1] = 1'b1; f3s[1] = 3'b001; adr[1] = 32'h13;
    ws[2] = 1'b0; f3s[2] = 3'b011; adr[2] = 32'h10;
    ws[3] = 1'b0; f3s[3] = 3'b010; adr[3] = 32'h1000;
    ws[4] = 1'b1; f3s[4] = 3'b100; adr[4] = 32'h10;
    for (int i = 0; i < 5; i++) begin
      issue(ws[i], f3s[i], adr[i], 32'hFFFFFFFF);
      @(negedge Clock);
      vectors++;
      if ({MemReadEn, MemWriteEnable, Busy, Fault} !== 4'b0000) begin
        $display("FAIL fault_req[%0d]: got re=%b we=%b busy=%b fault=%b want 0 0 0 0",
                 i, MemReadEn, MemWriteEnable, Busy, Fault);
        miscompares++;
      end
      @(posedge Clock); #1 idle_in();
      @(negedge Clock);
      vectors++;
      if ({Fault, Busy, LoadValid, LoadData} !== {3'b100, last_load}) begin
        $display("FAIL fault_pulse[%0d]: got fault=%b busy=%b lv=%b ld=%h want 1 0 0 %h",
                 i, Fault, Busy, LoadValid, LoadData, last_load);
        miscompares++;
      end
      @(posedge Clock); #1;
    end
    @(negedge Clock);
    vectors++;
    if (Fault !== 1'b0) begin
      $display("FAIL fault_clear: got %b want 0", Fault);
      miscompares++;
    end
`ifdef LSU_PERF_CNT_EN
    vectors++;
    if (FaultCount !== 32'(exp_fc)) begin
      $display("FAIL fault_count: got %0d want %0d", FaultCount, exp_fc);
      miscompares++;
    end
`endif
    @(posedge Clock); #1;
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] old;
    int lat;
    old = ref_mem[4];
    issue(1'b1, 3'b001, 32'h10, 32'hCAFE1234);
    @(posedge Clock); #1 idle_in();
    #1 Reset = 1'b0;
    #1;
    vectors++;
    if ({MemWriteEnable, MemReadEn, Busy, LoadValid, Fault, LoadData} !== 37'h0) begin
      $display("FAIL abort_outputs: got we=%b re=%b busy=%b lv=%b fault=%b ld=%h want all 0",
               MemWriteEnable, MemReadEn, Busy, LoadValid, Fault, LoadData);
      miscompares++;
    end
    repeat (2) @(posedge Clock);
    #1;
    vectors++;
    if (tb_mem[4] !== old) begin
      $display("FAIL abort_mem: got word4=%h want %h", tb_mem[4], old);
      miscompares++;
    end
    Reset = 1'b1;
    exp_lc = 0; exp_sc = 0; exp_fc = 0; last_load = 32'h0;
    run_load(3'b010, 32'h10, old, lat);
    vectors++;
    if (lat !== 2) begin
      $display("FAIL abort_recover_latency: got %0d want 2", lat);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    Reset = 1'b0;
    #1 Reset = 1'b1;
    exp_lc = 0; exp_sc = 0; exp_fc = 0; last_load = 32'h0;
    @(posedge Clock); #1;
    exp_load.push_back(ref_mem[4]);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge Clock); #1;
    exp_wr.push_back({32'd8, 32'h0BADF00D});
    ref_mem[8] = 32'h0BADF00D;
    issue(1'b1, 3'b010, 32'h20, 32'h0BADF00D);
    @(negedge Clock);
    vectors++;
    if ({Busy, MemWriteEnable} !== 2'b10) begin
      $display("FAIL b2b_held: got busy=%b we=%b want 1 0", Busy, MemWriteEnable);
      miscompares++;
    end
    @(posedge Clock); #1;
    @(negedge Clock);
    vectors++;
    if ({LoadValid, Busy, MemWriteEnable, MemAddress} !== {3'b101, 32'd8}) begin
      $display("FAIL b2b_accept: got lv=%b busy=%b we=%b addr=%h want 1 0 1 8",
               LoadValid, Busy, MemWriteEnable, MemAddress);
      miscompares++;
    end
    @(posedge Clock); #1 idle_in();
    @(negedge Clock);
`ifdef LSU_PERF_CNT_EN
    vectors++;
    if ({LoadCount, StoreCount} !== {32'd1, 32'd1} || exp_lc != 1 || exp_sc != 1) begin
      $display("FAIL b2b_counts: got loads=%0d stores=%0d want 1 1", LoadCount, StoreCount);
      miscompares++;
    end
`endif
    @(posedge Clock); #1;
    run_load(3'b010, 32'h20, 32'h0BADF00D, lat);
    vectors++;
    if (lat !== 2) begin
      $display("FAIL b2b_reload_latency: got %0d want 2", lat);
      miscompares++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    idle_in();
    Reset = 1'b0;
    test_reset();
    test_store_word();
    test_loads();
    test_sub_word_store();
    test_faults();
    test_reset_mid_rmw();
    test_back_to_back();
    repeat (3) @(posedge Clock);
    vectors++;
    if (exp_load.size() != 0 || exp_wr.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d loads %0d writes pending want 0 0",
               exp_load.size(), exp_wr.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
